// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the pipeline controller.
// The stages drive the stall requests and the exception information.
// The controller answers in the same cycle with stall, flush and new_pc.
// timeout_o and stall_cycles are registered and change only on a clock edge.
// fsm_state mirrors the controller state register so that checkers can bind to it.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        timeout_o;
    logic [31:0] stall_cycles;
    logic [1:0]  fsm_state;

    // Pipeline stages side.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, timeout_o, stall_cycles, fsm_state
    );

    // Controller side.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, timeout_o, stall_cycles, fsm_state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller. It produces the per-stage stall vector and the flush/redirect signals.
// It also forces a bus-timeout exception when the memory stage stalls for too long.
// The priority within one cycle is: reset, then exception, then timeout, then stall requests.
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        FLUSH   = 2'b10
    } state_t;

    // The count that triggers the timeout. The count starts from the first MEMWAIT cycle.
    localparam logic [15:0] TMO_LAST = 16'(STALL_TIMEOUT - 1);
    localparam logic [31:0] EXC_VEC  = 32'h0000_0040;
    localparam logic [31:0] INT_VEC  = 32'h0000_0020;

    state_t      state;
    state_t      state_next;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_cnt_next;
    logic        tmo_take;
    logic        timeout_q;
    logic [31:0] stall_cycles_q;
    logic        exc;
    logic [5:0]  stall_v;
    logic        flush_v;
    logic [31:0] new_pc_v;
    logic [31:0] exc_target;

    assign exc = (bus.excepttype_i != 32'h0);

    // Select the redirect target for the pending exception code.
    always_comb begin
        exc_target = EXC_VEC;
        case (bus.excepttype_i)
            32'h0000_0001: exc_target = INT_VEC;
            32'h0000_000e: exc_target = bus.cp0_epc_i;
            default:       exc_target = EXC_VEC;
        endcase
    end

    // Compute the next state, the timeout counter and the same-cycle pipeline controls.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        stall_v      = 6'b000000;
        flush_v      = 1'b0;
        new_pc_v     = 32'h0;
        tmo_take     = 1'b0;
        if (rst) begin
            // All outputs stay at zero. The register block loads the reset state.
            state_next   = RUN;
            tmo_cnt_next = 16'h0;
        end else if (exc) begin
            flush_v      = 1'b1;
            new_pc_v     = exc_target;
            state_next   = FLUSH;
            tmo_cnt_next = 16'h0;
        end else if (state == MEMWAIT && bus.stallreq_mem && tmo_cnt == TMO_LAST) begin
            flush_v      = 1'b1;
            new_pc_v     = EXC_VEC;
            tmo_take     = 1'b1;
            state_next   = FLUSH;
            tmo_cnt_next = 16'h0;
        end else begin
            if (bus.stallreq_mem)      stall_v = 6'b011111;
            else if (bus.stallreq_ex)  stall_v = 6'b001111;
            else if (bus.stallreq_id)  stall_v = 6'b000111;
            else if (bus.stallreq_if)  stall_v = 6'b000011;
            case (state)
                RUN: begin
                    if (bus.stallreq_mem) state_next = MEMWAIT;
                end
                MEMWAIT: begin
                    if (bus.stallreq_mem) begin
                        tmo_cnt_next = tmo_cnt + 16'h1;
                    end else begin
                        state_next   = RUN;
                        tmo_cnt_next = 16'h0;
                    end
                end
                FLUSH: begin
                    state_next   = bus.stallreq_mem ? MEMWAIT : RUN;
                    tmo_cnt_next = 16'h0;
                end
                default: begin
                    state_next   = RUN;
                    tmo_cnt_next = 16'h0;
                end
            endcase
        end
    end

    // Registered state: the FSM, the timeout counter, the timeout pulse and the stall cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            tmo_cnt        <= 16'h0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= 32'h0;
        end else begin
            state     <= state_next;
            tmo_cnt   <= tmo_cnt_next;
            timeout_q <= tmo_take;
            if (stall_v != 6'b000000) stall_cycles_q <= stall_cycles_q + 32'h1;
        end
    end

    assign bus.stall        = stall_v;
    assign bus.flush        = flush_v;
    assign bus.new_pc       = new_pc_v;
    assign bus.timeout_o    = timeout_q;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. The DUT is built with STALL_TIMEOUT = 4.
// Each step drives the inputs and pushes the expected cycle result onto exp_q.
// At the falling edge the bench pops the entry and compares the combinational outputs.
// After the next rising edge it compares the registered outputs.
module tb_pipe_ctrl;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MW  = 2'b01;
    localparam logic [1:0] S_FL  = 2'b10;

    logic clk;
    logic rst;
    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sc = 32'h0;
    // Each entry holds {stall, flush, new_pc, timeout_o after the edge, state after the edge}.
    logic [41:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: sets every DUT input in one call.
    task automatic drive(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                         input logic [31:0] code, input logic [31:0] epc);
        bus.stallreq_if  = r_if;
        bus.stallreq_id  = r_id;
        bus.stallreq_ex  = r_ex;
        bus.stallreq_mem = r_mem;
        bus.excepttype_i = code;
        bus.cp0_epc_i    = epc;
    endtask

    // Runs one clock cycle against the expected result.
    // The task is entered and left 1 time unit after a rising edge.
    task automatic cyc(input string tag, input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic e_tmo, input logic [1:0] e_state);
        logic [41:0] e;
        exp_q.push_back({e_stall, e_flush, e_pc, e_tmo, e_state});
        if (rst) exp_sc = 32'h0;
        else if (e_stall != 6'b000000) exp_sc = exp_sc + 32'h1;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".stall"},  64'(bus.stall),  64'(e[41:36]));
            check({tag, ".flush"},  64'(bus.flush),  64'(e[35]));
            check({tag, ".new_pc"}, 64'(bus.new_pc), 64'(e[34:3]));
            @(posedge clk);
            #1;
            check({tag, ".timeout_o"},    64'(bus.timeout_o),    64'(e[2]));
            check({tag, ".state"},        64'(bus.fsm_state),    64'(e[1:0]));
            check({tag, ".stall_cycles"}, 64'(bus.stall_cycles), 64'(exp_sc));
        end
    endtask

    // Reference table mapping an exception code to its redirect target.
    function automatic logic [31:0] target_of(input logic [31:0] code, input logic [31:0] epc);
        if (code == 32'h1)      return 32'h20;
        else if (code == 32'he) return epc;
        else                    return 32'h40;
    endfunction

    logic [31:0] codes[7];
    logic [31:0] epc;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;

        // While reset is held, every output is zero even when all requests are raised.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h55);
        cyc("rst_hold", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("idle", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        // Execute and decode stall requests held together for three cycles.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
            cyc("ex_id", 6'b001111, 1'b0, 32'h0, 1'b0, S_RUN);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("if_only", 6'b000011, 1'b0, 32'h0, 1'b0, S_RUN);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("id_if", 6'b000111, 1'b0, 32'h0, 1'b0, S_RUN);

        // An eret arrives together with a memory stall. The exception wins.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'he, 32'h1234);
        cyc("eret", 6'b000000, 1'b1, 32'h1234, 1'b0, S_FL);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        cyc("flush_ex", 6'b001111, 1'b0, 32'h0, 1'b0, S_RUN);

        // Back-to-back exceptions cover every code class, with random EPCs.
        codes[0] = 32'h1;  codes[1] = 32'h8;  codes[2] = 32'ha;  codes[3] = 32'hc;
        codes[4] = 32'hd;  codes[5] = 32'he;  codes[6] = $urandom_range(16, 4095);
        for (int k = 0; k < 7; k++) begin
            epc = $urandom;
            drive(1'b0, 1'b1, 1'b0, 1'b1, codes[k], epc);
            cyc("exc_code", 6'b000000, 1'b1, target_of(codes[k], epc), 1'b0, S_FL);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("idle2", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        // A memory stall held until the bus timeout fires.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) cyc("mem_wait", 6'b011111, 1'b0, 32'h0, 1'b0, S_MW);
        cyc("timeout", 6'b000000, 1'b1, 32'h40, 1'b1, S_FL);
        cyc("post_tmo", 6'b011111, 1'b0, 32'h0, 1'b0, S_MW);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("mem_done", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        // An exception after three memory-stall cycles preempts the timeout.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) cyc("mem_pre", 6'b011111, 1'b0, 32'h0, 1'b0, S_MW);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0);
        cyc("exc_preempt", 6'b000000, 1'b1, 32'h20, 1'b0, S_FL);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("no_tmo", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        // Reset in the middle of MEMWAIT discards the count. A fresh stall needs the full count again.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) cyc("mem_rst", 6'b011111, 1'b0, 32'h0, 1'b0, S_MW);
        rst = 1'b1;
        cyc("rst_mw", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cyc("mem_restart", 6'b011111, 1'b0, 32'h0, 1'b0, S_MW);
        cyc("timeout2", 6'b000000, 1'b1, 32'h40, 1'b1, S_FL);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("idle3", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        // Preload the stall cycle counter near its limit, then check that it wraps to zero.
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        exp_sc = 32'hFFFF_FFFE;
        check("preload", 64'(bus.stall_cycles), 64'(exp_sc));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        cyc("wrap_max", 6'b001111, 1'b0, 32'h0, 1'b0, S_RUN);
        cyc("wrap_zero", 6'b001111, 1'b0, 32'h0, 1'b0, S_RUN);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("idle4", 6'b000000, 1'b0, 32'h0, 1'b0, S_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: STALL_TIMEOUT, default 255; consecutive cycles of stallreq_mem before a bus-timeout exception is forced (legal range 2..65535).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset (rst == RstEnable == 1'b1), sampled on rising clk edge.
REQ-004 Port: stallreq_if  in  1  fetch-side stall request (instruction bus busy).
REQ-005 Port: stallreq_id  in  1  decode stall request (load-use hazard).
REQ-006 Port: stallreq_ex  in  1  execute stall request (multi-cycle mul/div).
REQ-007 Port: stallreq_mem  in  1  memory-stage stall request (data bus busy).
REQ-008 Port: excepttype_i  in  32  exception code from memory stage; zero = none.
REQ-009 Port: cp0_epc_i  in  32  current CP0 EPC, used for eret.
REQ-010 Port: stall  out  6  per-stage hold vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop.
REQ-011 Port: flush  out  1  clear all pipeline registers at next edge.
REQ-012 Port: new_pc  out  32  redirect target, valid only while flush = 1.
REQ-013 Port: timeout_o  out  1  one-cycle pulse, bus timeout taken.
REQ-014 Port: stall_cycles  out  32  count of cycles with stall != 0.

Function
REQ-015 stall, flush, new_pc shall be combinational from inputs and current state (same-cycle effect on pipeline registers); timeout_o and stall_cycles shall be registered.
REQ-016 Priority per cycle: rst > exception (excepttype_i != 0) > bus timeout > stall requests.
REQ-017 Exception present: flush = 1, stall = 6'b000000, new_pc by code: 0x00000001 -> 0x00000020; 0x00000008, 0x0000000a, 0x0000000c, 0x0000000d -> 0x00000040; 0x0000000e -> cp0_epc_i; any other nonzero -> 0x00000040.
REQ-018 No exception, no timeout: stall = 6'b011111 if stallreq_mem, else 6'b001111 if stallreq_ex, else 6'b000111 if stallreq_id, else 6'b000011 if stallreq_if, else 6'b000000; flush = 0, new_pc = 0.
REQ-019 FSM states RUN, MEMWAIT, FLUSH (2-bit encoding); reset state RUN.
REQ-020 RUN -> MEMWAIT when stallreq_mem = 1 and no exception; RUN -> FLUSH when flush asserted.
REQ-021 MEMWAIT: 16-bit tmo_cnt increments each cycle stallreq_mem = 1; MEMWAIT -> RUN when stallreq_mem = 0 (tmo_cnt cleared).
REQ-022 Timeout: in MEMWAIT with tmo_cnt == STALL_TIMEOUT-1 and stallreq_mem = 1 and no exception: flush = 1, stall = 0, new_pc = 0x00000040; timeout_o = 1 in next cycle; next state FLUSH; tmo_cnt cleared.
REQ-023 FLUSH lasts exactly one cycle: stall requests honoured per REQ-018, exceptions honoured per REQ-017 (back-to-back flush allowed); next state RUN, or MEMWAIT if stallreq_mem = 1, or FLUSH if flush asserted.
REQ-024 Exception arriving in MEMWAIT preempts timeout: flush per REQ-017, tmo_cnt cleared, next state FLUSH, timeout_o stays 0.
REQ-025 stall_cycles increments by 1 on each edge where stall != 0, wraps 0xFFFFFFFF -> 0; no saturation.
REQ-026 tmo_cnt never exceeds STALL_TIMEOUT-1.

Reset
REQ-027 On rst = 1 at edge: state = RUN, tmo_cnt = 0, timeout_o = 0, stall_cycles = 0.
REQ-028 While rst = 1: stall = 6'b000000, flush = 0, new_pc = 0x00000000 regardless of inputs; reset mid-MEMWAIT discards count with no timeout pulse.

Verification
REQ-029 stallreq_ex = 1 and stallreq_id = 1 for 3 cycles -> stall = 6'b001111 each cycle, flush = 0, stall_cycles = 3 afterwards.
REQ-030 excepttype_i = 0x0000000e, cp0_epc_i = 0x00001234, stallreq_mem = 1 same cycle -> flush = 1, new_pc = 0x00001234, stall = 0, next state FLUSH.
REQ-031 STALL_TIMEOUT = 4, stallreq_mem held -> stall = 6'b011111 for 4 cycles, 5th... timeout cycle flush = 1, new_pc = 0x00000040, timeout_o = 1 one cycle later, exactly once.
REQ-032 stallreq_mem held 3 cycles then excepttype_i = 0x00000001 (STALL_TIMEOUT = 4) -> flush = 1, new_pc = 0x00000020, timeout_o never asserted.
REQ-033 rst asserted during MEMWAIT with stall_cycles = 10 -> next cycle stall_cycles = 0, state RUN, outputs zero; release then stallreq_mem -> full timeout count restarts.
REQ-034 stall_cycles preloaded via long run near 0xFFFFFFFF (force) plus one stalled cycle -> wraps to 0x00000000.
